// File: rtl/reg_bus_master.sv
// Register access bus initiator: one request at a time goes through a write or read
// bus phase, and each request gets exactly one response through a valid/ready handshake.
module reg_bus_master #(
  parameter int ADDR_W    = 33,
  parameter int DATA_W    = 33,
  parameter int RDATA_W   = 21,
  parameter int READ_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_write,
  output logic [RDATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]  address,
  output logic               write_enable,
  output logic [DATA_W-1:0]  write_data,
  output logic               read_enable,
  input  logic [RDATA_W-1:0] read_data,
  output logic               busy,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [3:0]         wait_q, wait_d;
  logic               rsp_write_q, rsp_write_d;
  logic [RDATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wait_d  = WAIT_INIT;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (~&wr_count_q) wr_count_d = wr_count_q + 1'b1;
        rsp_rdata_d = '0;
        rsp_write_d = 1'b1;
        state_d     = RESP;
      end
      READ: begin
        // read_enable stays up while the wait counter drains; sample on the zero cycle
        if (wait_q == 4'd0) begin
          if (~&rd_count_q) rd_count_d = rd_count_q + 1'b1;
          rsp_rdata_d = read_data;
          rsp_write_d = 1'b0;
          state_d     = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    busy         = (state_q != IDLE);
    rsp_valid    = (state_q == RESP);
    write_enable = (state_q == WRITE);
    read_enable  = (state_q == READ);
    address      = (state_q == WRITE || state_q == READ) ? addr_q : '0;
    write_data   = (state_q == WRITE) ? wdata_q : '0;
    rsp_write    = rsp_write_q;
    rsp_rdata    = rsp_rdata_q;
    wr_count     = wr_count_q;
    rd_count     = rd_count_q;
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a default-parameter instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_reg_bus_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [32:0] req_addr = '0, req_wdata = '0;
  logic [20:0] read_data = '0;

  logic        req_ready, rsp_valid, rsp_write, write_enable, read_enable, busy;
  logic [20:0] rsp_rdata;
  logic [32:0] address, write_data;
  logic [15:0] wr_count, rd_count;

  logic        req_ready4, rsp_valid4, rsp_write4, write_enable4, read_enable4, busy4;
  logic [20:0] rsp_rdata4;
  logic [32:0] address4, write_data4;
  logic [3:0]  wr_count4, rd_count4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_bus_master #(.ADDR_W(33), .DATA_W(33), .RDATA_W(21), .READ_WAIT(1), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .address(address), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(read_data),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count));

  reg_bus_master #(.ADDR_W(33), .DATA_W(33), .RDATA_W(21), .READ_WAIT(1), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_write(rsp_write4),
    .rsp_rdata(rsp_rdata4), .address(address4), .write_enable(write_enable4),
    .write_data(write_data4), .read_enable(read_enable4), .read_data(read_data),
    .busy(busy4), .wr_count(wr_count4), .rd_count(rd_count4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; everything is driven and sampled 1ns after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic simple_write(input logic [32:0] a, input logic [32:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_address", address, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_re", read_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    step();
    reset = 1'b0;
    step();

    // 1: single write with rsp_ready high
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 33'hAA; req_wdata = 33'h1_2345;
    chk("t1_c0_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("t1_c1_we", write_enable, 1);
    chk("t1_c1_addr", address, 33'hAA);
    chk("t1_c1_wdata", write_data, 33'h1_2345);
    chk("t1_c1_ready", req_ready, 0);
    chk("t1_c1_rsp_valid", rsp_valid, 0);
    step();
    chk("t1_c2_we", write_enable, 0);
    chk("t1_c2_addr", address, 0);
    chk("t1_c2_rsp_valid", rsp_valid, 1);
    chk("t1_c2_rsp_write", rsp_write, 1);
    chk("t1_c2_rsp_rdata", rsp_rdata, 0);
    chk("t1_c2_wr_count", wr_count, 1);
    step();
    chk("t1_c3_idle", busy, 0);
    chk("t1_c3_rsp_valid", rsp_valid, 0);

    // 2: read with one wait cycle
    read_data = 21'h0_0007;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 33'h55;
    step();
    req_valid = 1'b0;
    chk("t2_c1_re", read_enable, 1);
    chk("t2_c1_addr", address, 33'h55);
    chk("t2_c1_we", write_enable, 0);
    step();
    chk("t2_c2_re", read_enable, 1);
    chk("t2_c2_rsp_valid", rsp_valid, 0);
    step();
    chk("t2_c3_re", read_enable, 0);
    chk("t2_c3_rsp_valid", rsp_valid, 1);
    chk("t2_c3_rsp_write", rsp_write, 0);
    chk("t2_c3_rsp_rdata", rsp_rdata, 21'h7);
    chk("t2_c3_rd_count", rd_count, 1);
    step();
    chk("t2_c4_idle", req_ready, 1);

    // 3: read response held off by rsp_ready=0 for 5 cycles
    rsp_ready = 1'b0;
    read_data = 21'h1_ABCD;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 33'h123;
    step();
    req_valid = 1'b0;
    step();
    step();
    read_data = 21'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_rsp_valid", rsp_valid, 1);
      chk("t3_hold_rsp_rdata", rsp_rdata, 21'h1_ABCD);
      chk("t3_hold_req_ready", req_ready, 0);
      chk("t3_hold_re", read_enable, 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("t3_last_rsp_valid", rsp_valid, 1);
    step();
    chk("t3_idle_ready", req_ready, 1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_rd_count", rd_count, 2);

    // 4: req_valid held high across three back-to-back writes
    req_valid = 1'b1; req_write = 1'b1;
    for (int w = 0; w < 3; w++) begin
      req_addr = 33'h100 + 33'(w); req_wdata = 33'h1_0000_0000 | 33'(w);
      chk("t4_c0_ready", req_ready, 1);
      step();
      chk("t4_c1_we", write_enable, 1);
      chk("t4_c1_addr", address, 33'h100 + 33'(w));
      chk("t4_c1_wdata", write_data, 33'h1_0000_0000 | 33'(w));
      chk("t4_c1_ready", req_ready, 0);
      if (w == 2) req_valid = 1'b0;
      step();
      chk("t4_c2_we", write_enable, 0);
      chk("t4_c2_rsp_valid", rsp_valid, 1);
      step();
    end
    chk("t4_wr_count", wr_count, 4);
    chk("t4_idle", busy, 0);

    // 5: reset asserted while read_enable is high
    req_valid = 1'b1; req_write = 1'b0; req_addr = 33'h77; read_data = 21'h15;
    step();
    req_valid = 1'b0;
    chk("t5_pre_re", read_enable, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_re", read_enable, 0);
    chk("t5_async_addr", address, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", req_ready, 1);
    chk("t5_async_rd_count", rd_count, 0);
    chk("t5_async_wr_count", wr_count, 0);
    step();
    reset = 1'b0;
    step();
    chk("t5_post_rsp_valid", rsp_valid, 0);
    chk("t5_post_busy", busy, 0);
    chk("t5_post_rd_count", rd_count, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 33'h3; req_wdata = 33'h1_0000_0001;
    step();
    req_valid = 1'b0;
    chk("t5_next_we", write_enable, 1);
    chk("t5_next_wdata", write_data, 33'h1_0000_0001);
    step();
    chk("t5_next_rsp_valid", rsp_valid, 1);
    chk("t5_next_wr_count", wr_count, 1);
    step();

    // 6: CNT_W=4 counter saturates at 0xF
    chk("t6_start4", wr_count4, 1);
    for (int n = 2; n <= 17; n++) begin
      simple_write(33'(n), 33'(n * 3));
      chk("t6_wr_count4", wr_count4, (n > 15) ? 15 : n);
    end
    chk("t6_wr_count16", wr_count, 17);
    chk("t6_rd_count4", rd_count4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
